// File: rtl/ahb_lite_fir_cfg_slave_if.sv
// AHB-Lite bus bundle between the master and the FIR configuration slave.
interface ahb_lite_fir_cfg_slave_if #(
  parameter int HADDR_W = 6
);
  logic               hsel;
  logic [1:0]         htrans;
  logic [HADDR_W-1:0] haddr;
  logic [1:0]         hsize;
  logic               hwrite;
  logic [15:0]        hwdata;
  logic [15:0]        hrdata;
  logic               hready;
  logic               hresp;

  modport slave (
    input  hsel, htrans, haddr, hsize, hwrite, hwdata,
    output hrdata, hready, hresp
  );

  modport master (
    output hsel, htrans, haddr, hsize, hwrite, hwdata,
    input  hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_fir_cfg_slave.sv
// AHB-Lite register/coefficient/sample-FIFO front end for the FIR filter.
// Optional interrupt output enabled by defining FIR_CFG_IRQ_EN.
module ahb_lite_fir_cfg_slave #(
  parameter int NUM_COEFF    = 4,
  parameter int SAMPLE_DEPTH = 4,
  parameter int HADDR_W      = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  ahb_lite_fir_cfg_slave_if.slave      bus,
  input  logic                         modwait,
  input  logic                         err,
  input  logic [15:0]                  fir_out,
  input  logic [$clog2(NUM_COEFF)-1:0] coefficient_num,
  input  logic                         coeff_load_done,
  input  logic                         sample_ack,
  output logic [15:0]                  fir_coefficient,
  output logic [15:0]                  sample_data,
  output logic                         data_ready,
  output logic                         new_coefficient_set
`ifdef FIR_CFG_IRQ_EN
  ,output logic                        irq
`endif
);
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam int         AW        = $clog2(SAMPLE_DEPTH);

  logic [15:0]        coeff [NUM_COEFF];
  logic [15:0]        mem   [SAMPLE_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, count;
  logic [15:0]        last_sample;
  logic               ovf;

  logic               dp_valid, dp_write, dp_byte, dp_odd, dp_static_err, err2_q;
  logic [HADDR_W-2:0] dp_hidx;
  int                 a_h, dp_h;
  logic               accept, a_err, fifo_full;
  logic               push_ovf, err_now, wr_ok, rd_ok, push, pop, ctrl_wr, status_rd;
  logic [15:0]        status, rv;
  logic               irq_bit;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic byte_en, input logic odd);
    if (!byte_en) return wd;
    return odd ? {wd[15:8], old[7:0]} : {old[15:8], wd[7:0]};
  endfunction

  // Address phase: everything that can be decided without the data or FIFO state.
  assign a_h    = int'(bus.haddr[HADDR_W-1:1]);
  assign accept = bus.hsel && (bus.htrans == HT_NONSEQ) && bus.hready;
  assign a_err  = (bus.hsize >= 2'd2) || (a_h >= 4 + NUM_COEFF) ||
                  (bus.hwrite && a_h < 2) ||
                  (bus.hwrite && a_h == 2 && bus.hsize == 2'd0);

  // Data phase: overflow depends on the FIFO level in this very cycle.
  assign dp_h      = int'(dp_hidx);
  assign count     = wr_ptr - rd_ptr;
  assign fifo_full = (count == (AW+1)'(SAMPLE_DEPTH));
  assign push_ovf  = dp_valid && dp_write && !dp_static_err && dp_h == 2 &&
                     fifo_full && !sample_ack;
  assign err_now   = dp_valid && (dp_static_err || push_ovf);
  assign wr_ok     = dp_valid && !err_now && dp_write;
  assign rd_ok     = dp_valid && !err_now && !dp_write;
  assign push      = wr_ok && dp_h == 2;
  assign pop       = sample_ack && (count != '0);
  assign ctrl_wr   = wr_ok && dp_h == 3 && !(dp_byte && dp_odd);
  assign status_rd = rd_ok && dp_h == 0;

  assign bus.hready = !err_now;
  assign bus.hresp  = err_now || err2_q;

  assign data_ready  = (count != '0);
  assign sample_data = mem[rd_ptr[AW-1:0]];
  assign status      = {irq_bit, 6'b0, err, 4'b0, ovf, fifo_full, data_ready,
                        new_coefficient_set | modwait};

  always_comb begin
    rv = '0;
    case (dp_h)
      0: rv = status;
      1: rv = fir_out;
      2: rv = last_sample;
      3: rv = {15'b0, new_coefficient_set};
      default: for (int i = 0; i < NUM_COEFF; i++) if (dp_h == 4 + i) rv = coeff[i];
    endcase
  end

  always_comb begin
    bus.hrdata = '0;
    if (rd_ok) bus.hrdata = !dp_byte ? rv : (dp_odd ? {rv[15:8], 8'h0} : {8'h0, rv[7:0]});
  end

  always_comb begin
    fir_coefficient = '0;
    for (int i = 0; i < NUM_COEFF; i++)
      if (int'(coefficient_num) == i) fir_coefficient = coeff[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0; dp_write <= 1'b0; dp_byte <= 1'b0; dp_odd <= 1'b0;
      dp_static_err <= 1'b0; dp_hidx <= '0; err2_q <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0; last_sample <= '0; ovf <= 1'b0;
      new_coefficient_set <= 1'b0;
      for (int i = 0; i < NUM_COEFF; i++)    coeff[i] <= '0;
      for (int i = 0; i < SAMPLE_DEPTH; i++) mem[i]   <= '0;
    end else begin
      dp_valid <= accept;
      err2_q   <= err_now;
      if (accept) begin
        dp_write      <= bus.hwrite;
        dp_byte       <= (bus.hsize == 2'd0);
        dp_odd        <= bus.haddr[0];
        dp_hidx       <= bus.haddr[HADDR_W-1:1];
        dp_static_err <= a_err;
      end
      for (int i = 0; i < NUM_COEFF; i++)
        if (wr_ok && dp_h == 4 + i) coeff[i] <= merge(coeff[i], bus.hwdata, dp_byte, dp_odd);
      // A same-cycle control write takes priority over the FIR's load-done pulse.
      if (ctrl_wr)              new_coefficient_set <= bus.hwdata[0];
      else if (coeff_load_done) new_coefficient_set <= 1'b0;
      if (push_ovf)                     ovf <= 1'b1;
      else if (ctrl_wr && bus.hwdata[1]) ovf <= 1'b0;
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.hwdata;
        wr_ptr              <= wr_ptr + 1'b1;
        last_sample         <= bus.hwdata;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef FIR_CFG_IRQ_EN
  logic err_q, ovf_set_q;
  assign irq_bit = irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0; ovf_set_q <= 1'b0; irq <= 1'b0;
    end else begin
      err_q     <= err;
      ovf_set_q <= push_ovf;
      // Set wins over a clearing status read in the same cycle.
      irq       <= (err && !err_q) || ovf_set_q || (irq && !status_rd);
    end
  end
`else
  assign irq_bit = 1'b0;
`endif
endmodule
